// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line parameters and the
// parity helper, common to the transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam bit          UART_PARITY_EN    = 1'b0;
    localparam bit          UART_PARITY_ODD   = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the byte; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/piso.sv
// 8-bit parallel-load, shift-right register; serial_out is always bit 0.
module piso (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] data_in,
    output logic       serial_out
);

    logic [7:0] shreg;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= 8'h00;
        end else if (load) begin
            shreg <= data_in;
        end else if (shift) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    assign serial_out = shreg[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, eight data bits LSB first, optional parity bit,
// one stop bit. Valid/ready handshake, registered glitch-free tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = UART_PARITY_EN,
    parameter bit          PARITY_ODD   = UART_PARITY_ODD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state;
    uart_state_e      next_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             parity_q;
    logic             tx_q;
    logic             tx_d;
    logic             handshake;
    logic             bit_done;
    logic             load;
    logic             shift;
    logic             serial_out;

    assign handshake = valid && (state == IDLE);
    assign bit_done  = (state != IDLE) && (baud_cnt == BAUD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (valid)    next_state = START;
            START:  if (bit_done) next_state = DATA;
            DATA:   if (bit_done && (bit_idx == 3'd7)) begin
                        next_state = PARITY_EN ? PARITY : STOP;
                    end
            PARITY: if (bit_done) next_state = STOP;
            STOP:   if (bit_done) next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Output logic. tx_d is the line value for the next bit, registered below;
    // the piso shifts on the same edge that tx_q takes its current bit 0.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state != IDLE);
        load  = handshake;
        shift = bit_done && ((state == START) || (state == DATA));
        tx_d  = tx_q;
        if (state == IDLE) begin
            tx_d = !handshake;
        end else if (bit_done) begin
            unique case (next_state)
                DATA:    tx_d = serial_out;
                PARITY:  tx_d = parity_q;
                default: tx_d = 1'b1;
            endcase
        end
    end

    // Baud counter, bit index, captured parity and the line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            if ((state == IDLE) || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // Parity comes from the byte as captured, not the live input.
            if (handshake) begin
                parity_q <= parity_bit(data_in, PARITY_ODD);
            end

            tx_q <= tx_d;
        end
    end

    assign tx = tx_q;

    piso u_piso (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift      (shift),
        .data_in    (data_in),
        .serial_out (serial_out)
    );

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three CLKS_PER_BIT=4 instances (no parity, even,
// odd) sharing stimulus, plus a CLKS_PER_BIT=16 instance with a bench receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data_in;
    logic       valid16;
    logic [7:0] data16;

    logic tx_m, ready_m, busy_m;
    logic tx_e, ready_e, busy_e;
    logic tx_o, ready_o, busy_o;
    logic tx16, ready16, busy16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready_m), .tx(tx_m), .busy(busy_m)
    );
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_e (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready_e), .tx(tx_e), .busy(busy_e)
    );
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_o (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready_o), .tx(tx_o), .busy(busy_o)
    );
    uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut16 (
        .clk(clk), .rst(rst), .data_in(data16), .valid(valid16),
        .ready(ready16), .tx(tx16), .busy(busy16)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst     = 1'b1;
        valid   = 1'b0;
        valid16 = 1'b0;
        data_in = 8'h00;
        data16  = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    // Check a full no-parity frame on the main instance, starting right after
    // the handshake edge; k counts cycles after that edge.
    task automatic check_frame_m(input string tag, input logic [9:0] f);
        for (int k = 0; k <= 40; k++) begin
            check1($sformatf("%s_tx_k%0d", tag, k), tx_m, (k < 40) ? f[k / 4] : 1'b1);
            if (k == 0)  check1({tag, "_busy_start"}, busy_m, 1'b1);
            if (k == 39) check1({tag, "_ready_k39"}, ready_m, 1'b0);
            if (k == 40) check1({tag, "_ready_k40"}, ready_m, 1'b1);
            tick();
        end
    endtask

    initial begin
        logic [9:0]  f_a5, f_00, f_ff, f_3c, f_55, f_f0;
        logic [10:0] f_a5_even, f_a5_odd;
        logic [7:0]  lb_bytes [4];
        logic [7:0]  rx;
        int          n;

        // Frames written out as {stop, [parity,] D7..D0, start}; bit 0 goes first.
        f_a5      = 10'b1_1010_0101_0;
        f_00      = 10'b1_0000_0000_0;
        f_ff      = 10'b1_1111_1111_0;
        f_3c      = 10'b1_0011_1100_0;
        f_55      = 10'b1_0101_0101_0;
        f_f0      = 10'b1_1111_0000_0;
        f_a5_even = 11'b1_0_1010_0101_0;
        f_a5_odd  = 11'b1_1_1010_0101_0;
        lb_bytes  = '{8'h00, 8'hFF, 8'h5A, 8'h81};

        // Reset state.
        reset_all();
        check1("rst_tx_m", tx_m, 1'b1);
        check1("rst_busy_m", busy_m, 1'b0);
        check1("rst_ready_m", ready_m, 1'b1);
        check1("rst_tx_e", tx_e, 1'b1);
        check1("rst_ready16", ready16, 1'b1);

        // 0xA5 on all three CLKS_PER_BIT=4 instances.
        valid = 1'b1;
        data_in = 8'hA5;
        tick();
        valid = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k <= 44; k++) begin
            check1($sformatf("a5_m_k%0d", k), tx_m, (k < 40) ? f_a5[k / 4] : 1'b1);
            check1($sformatf("a5_even_k%0d", k), tx_e, (k < 44) ? f_a5_even[k / 4] : 1'b1);
            check1($sformatf("a5_odd_k%0d", k), tx_o, (k < 44) ? f_a5_odd[k / 4] : 1'b1);
            if (k == 39) check1("a5_m_ready_k39", ready_m, 1'b0);
            if (k == 40) check1("a5_m_ready_k40", ready_m, 1'b1);
            if (k == 40) check1("a5_m_busy_k40", busy_m, 1'b0);
            if (k == 43) check1("a5_even_ready_k43", ready_e, 1'b0);
            if (k == 44) check1("a5_even_ready_k44", ready_e, 1'b1);
            if (k == 44) check1("a5_odd_busy_k44", busy_o, 1'b0);
            tick();
        end

        // Back-to-back 0x00 then 0xFF with valid held high.
        reset_all();
        valid = 1'b1;
        data_in = 8'h00;
        tick();
        data_in = 8'hFF;
        for (int k = 0; k <= 81; k++) begin
            logic exp_tx;
            if (k < 40)       exp_tx = f_00[k / 4];
            else if (k == 40) exp_tx = 1'b1;
            else if (k < 81)  exp_tx = f_ff[(k - 41) / 4];
            else              exp_tx = 1'b1;
            check1($sformatf("b2b_tx_k%0d", k), tx_m, exp_tx);
            if (k == 40) check1("b2b_ready_k40", ready_m, 1'b1);
            if (k == 41) begin
                check1("b2b_busy_k41", busy_m, 1'b1);
                valid = 1'b0;
            end
            tick();
        end

        // 0x3C while data_in churns with valid high for the whole frame.
        reset_all();
        valid = 1'b1;
        data_in = 8'h3C;
        tick();
        for (int k = 0; k <= 40; k++) begin
            data_in = 8'($urandom_range(0, 255));
            check1($sformatf("churn_tx_k%0d", k), tx_m, (k < 40) ? f_3c[k / 4] : 1'b1);
            check1($sformatf("churn_ready_k%0d", k), ready_m, (k == 40));
            if (k == 40) valid = 1'b0;
            tick();
        end

        // Reset in the middle of D3 of 0x55, then a clean 0xF0 frame.
        reset_all();
        valid = 1'b1;
        data_in = 8'h55;
        tick();
        valid = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            check1($sformatf("abort_tx_k%0d", k), tx_m, f_55[k / 4]);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("abort_tx", tx_m, 1'b1);
        check1("abort_busy", busy_m, 1'b0);
        check1("abort_ready", ready_m, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check1($sformatf("abort_quiet_k%0d", k), tx_m, 1'b1);
        end
        valid = 1'b1;
        data_in = 8'hF0;
        tick();
        valid = 1'b0;
        check_frame_m("f0", f_f0);

        // Reset wins over a simultaneous handshake.
        valid = 1'b1;
        data_in = 8'hAA;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid = 1'b0;
        check1("rstpri_ready", ready_m, 1'b1);
        check1("rstpri_busy", busy_m, 1'b0);
        tick();
        check1("rstpri_tx", tx_m, 1'b1);
        check1("rstpri_busy_next", busy_m, 1'b0);

        // Loopback through a mid-bit sampling receiver at CLKS_PER_BIT=16.
        foreach (lb_bytes[i]) begin
            data16 = lb_bytes[i];
            valid16 = 1'b1;
            tick();
            valid16 = 1'b0;
            n = 0;
            while (tx16 !== 1'b0 && n < 40) begin
                tick();
                n++;
            end
            check1($sformatf("lb%0d_start_edge", i), tx16, 1'b0);
            repeat (8) tick();
            check1($sformatf("lb%0d_start_mid", i), tx16, 1'b0);
            rx = 8'h00;
            for (int b = 0; b < 8; b++) begin
                repeat (16) tick();
                rx[b] = tx16;
            end
            repeat (16) tick();
            check1($sformatf("lb%0d_stop", i), tx16, 1'b1);
            check8($sformatf("lb%0d_byte", i), rx, lb_bytes[i]);
            n = 0;
            while (ready16 !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check1($sformatf("lb%0d_ready", i), ready16, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter: PARITY_EN, 0, 1 inserts one parity bit between the data bits and the stop bit.
REQ-003 Parameter: PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: data_in  input  8  byte to transmit, sampled only on handshake.
REQ-007 Port: valid  input  1  data_in holds a byte to send.
REQ-008 Port: ready  output  1  block can accept a byte this cycle.
REQ-009 Port: tx  output  1  serial line, idle high.
REQ-010 Port: busy  output  1  a frame is in progress.

Function
REQ-011 The frame SHALL be 8N1 (start 0, eight data bits LSB first, stop 1), with one parity bit after D7 when PARITY_EN=1.
REQ-012 The block SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-013 A handshake SHALL occur on a rising edge where valid=1 and ready=1; data_in is captured into the shift register on that edge.
REQ-014 ready SHALL equal (state==IDLE); valid while not ready is ignored and no data is lost or queued.
REQ-015 tx SHALL drive the start bit (0) in the first cycle after the handshake (latency 1).
REQ-016 Every bit, including start, data, parity and stop, SHALL hold tx stable for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1.
REQ-017 Bit advance SHALL occur when the baud counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
REQ-018 In DATA, the shift register SHALL shift right one bit per bit period, with tx = register[0].
REQ-019 A 3-bit bit index SHALL count 0..7; DATA exits to PARITY (PARITY_EN=1) or STOP after index 7 completes.
REQ-020 The parity bit SHALL be the XOR of the eight captured bits, inverted when PARITY_ODD=1, and computed from the captured byte rather than the live data_in.
REQ-021 After STOP completes, the state SHALL return to IDLE; tx=1 and ready=1 in that cycle.
REQ-022 Back-to-back: with valid held high, the next start bit SHALL begin 1 cycle after IDLE is entered, giving a frame period of (10+PARITY_EN)*CLKS_PER_BIT+1 cycles.
REQ-023 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 Changes on data_in or valid during a frame SHALL not affect tx.
REQ-025 tx SHALL be registered and glitch-free, and SHALL never go low outside START or a 0 data/parity bit.

Reset
REQ-026 A rising edge with rst=1 SHALL force state IDLE, tx=1, busy=0, ready=1, baud counter 0, bit index 0 and shift register 0x00.
REQ-027 rst SHALL take priority over a simultaneous handshake; that byte is discarded.
REQ-028 Reset mid-frame SHALL abort the frame; tx=1 from the next cycle, and no partial frame resumes.

Structure
REQ-029 The state encoding and the default values of CLKS_PER_BIT, PARITY_EN and PARITY_ODD SHALL live in the shared uart package, for common use with the receive path.
REQ-030 The baud counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-031 The 8-bit parallel-load, shift-right register SHALL be a sub-module named piso, with ports load, shift, data_in[7:0], serial_out, clk and rst.
REQ-032 The FSM, baud counter and parity logic SHALL reside in uart_tx.

Verification
REQ-033 CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; start bit 1 cycle after handshake; ready high again 41 cycles after handshake.
REQ-034 CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> parity bit 0 (even); with PARITY_ODD=1 -> parity bit 1; frame 44 cycles.
REQ-035 valid held high with 0x00 then 0xFF -> second start bit begins exactly 41 cycles after the first; line shows 0x00 bits then 0xFF bits, and the stop bit is never shortened.
REQ-036 Send 0x3C and toggle data_in randomly with valid=1 during the frame -> tx carries only 0x3C and ready stays 0 until the frame ends.
REQ-037 Assert rst for 1 cycle during D3 of 0x55 -> next cycle tx=1, busy=0, ready=1; a new handshake of 0xF0 transmits a clean frame.
REQ-038 Loopback of tx into the team receiver (CLKS_PER_BIT=16), sending 0x00, 0xFF, 0x5A and 0x81 -> the received bytes match in order.
